ex_mc: RTL

Parametrised, multi-cycle execute stage and successor to the single-cycle `ex` stage. Covers the full RV32I integer ALU for opcodes `INST_TYPE_I` and `INST_TYPE_R_M`, plus an optional iterative M-extension multiply/divide unit. Sits between `id_ex` and `regs`. It adds a ready/valid handshake so the pipeline stalls while a MUL/DIV is in flight. All results are registered.

---
 rtl/ex_mc.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_mc.sv
// rtl/ex_mc.sv - multi-cycle RV32I/M execute stage with ready/valid stall
//
// Purpose: executes I-type and R-type integer ALU ops in one cycle and,
// when M_EXT != 0, the MUL/DIV/REM family on an iterative shift-add /
// restoring-divide datapath. All results are registered.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   valid_i/ready_o   instruction handshake; ready_o is high only in IDLE
//   flush_i           kills the presented or in-flight instruction
//   inst_addr_i       PC, pass-through only
//   inst_i            instruction word (opcode/funct3/funct7 decoded)
//   op1_i, op2_i      operands (op2_i carries the I-type immediate)
//   rd_addr_i         destination register
//   reg_wen_i         decode requests a write
//   rd_addr_o         registered destination register
//   rd_data_o         registered result
//   rd_wen_o          one-cycle write strobe
module ex_mc #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned M_EXT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  input  logic [31:0]     inst_addr_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            reg_wen_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o
);

  localparam int unsigned    SHW      = $clog2(XLEN);
  localparam logic [6:0]     OP_I     = 7'b0010011;
  localparam logic [6:0]     OP_R     = 7'b0110011;
  localparam logic [6:0]     F7_BASE  = 7'b0000000;
  localparam logic [6:0]     F7_ALT   = 7'b0100000;
  localparam logic [6:0]     F7_MUL   = 7'b0000001;
  localparam logic [SHW-1:0] CNT_LOAD = SHW'(XLEN - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              is_div_q, is_div_d;
  logic              sel_hi_q, sel_hi_d;
  logic              neg_q, neg_d;
  logic [4:0]        lat_addr_q, lat_addr_d;
  logic              lat_wen_q, lat_wen_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic              rd_wen_q, rd_wen_d;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [SHW-1:0]    shamt;
  logic              accept;

  logic unused_bits;
  assign unused_bits = ^{inst_addr_i, inst_i[24:15], inst_i[11:7]};

  assign opcode  = inst_i[6:0];
  assign funct3  = inst_i[14:12];
  assign funct7  = inst_i[31:25];
  assign shamt   = op2_i[SHW-1:0];
  assign ready_o = (state_q == S_IDLE);
  assign accept  = valid_i & ready_o & ~flush_i & ~rst;

  // Single-cycle ALU
  logic                   alu_ok, sub_sel, sra_sel;
  logic [XLEN-1:0]        alu_res;
  logic signed [XLEN-1:0] sra_res;

  assign sra_res = $signed(op1_i) >>> shamt;

  always_comb begin
    alu_ok  = 1'b0;
    sub_sel = 1'b0;
    sra_sel = 1'b0;
    alu_res = '0;
    if (opcode == OP_I) begin
      alu_ok  = 1'b1;
      sra_sel = inst_i[30];
    end else if (opcode == OP_R) begin
      if (funct7 == F7_BASE) begin
        alu_ok = 1'b1;
      end else if (funct7 == F7_ALT) begin
        alu_ok  = (funct3 == 3'd0) || (funct3 == 3'd5);
        sub_sel = 1'b1;
        sra_sel = 1'b1;
      end
    end
    case (funct3)
      3'd0:    alu_res = sub_sel ? (op1_i - op2_i) : (op1_i + op2_i);
      3'd1:    alu_res = op1_i << shamt;
      3'd2:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
      3'd3:    alu_res = {{(XLEN-1){1'b0}}, (op1_i < op2_i)};
      3'd4:    alu_res = op1_i ^ op2_i;
      3'd5:    alu_res = sra_sel ? sra_res : (op1_i >> shamt);
      3'd6:    alu_res = op1_i | op2_i;
      default: alu_res = op1_i & op2_i;
    endcase
  end

  // M-extension decode: signedness per operand, magnitudes, special cases
  logic            m_op, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, m_special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign m_op      = (opcode == OP_R) && (funct7 == F7_MUL) && (M_EXT != 0);
  assign a_signed  = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign b_signed  = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign a_neg     = a_signed & op1_i[XLEN-1];
  assign b_neg     = b_signed & op2_i[XLEN-1];
  assign a_mag     = a_neg ? -op1_i : op1_i;
  assign b_mag     = b_neg ? -op2_i : op2_i;
  assign div_zero  = (op2_i == '0);
  assign div_ovf   = ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
                     (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&op2_i);
  assign m_special = funct3[2] & (div_zero | div_ovf);
  // funct3[1] distinguishes REM/REMU from DIV/DIVU
  assign special_res = div_zero ? (funct3[1] ? op1_i : '1)
                                : (funct3[1] ? '0 : op1_i);

  // Iteration steps. acc_q holds {high, low}: for multiply low is the
  // multiplier being shifted out and high the running partial sum; for
  // divide high is the partial remainder and low the dividend/quotient.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, mul_full;
  logic [XLEN-1:0]   div_sel, fix_res;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  // Product sign is applied to the full double-width value before the
  // half is selected; quotient/remainder are negated individually.
  assign mul_full = neg_q ? -acc_q : acc_q;
  assign div_sel  = sel_hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign fix_res  = is_div_q ? (neg_q ? -div_sel : div_sel)
                             : (sel_hi_q ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    sel_hi_d   = sel_hi_q;
    neg_d      = neg_q;
    lat_addr_d = lat_addr_q;
    lat_wen_d  = lat_wen_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    rd_wen_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (m_op && !m_special) begin
            state_d    = S_BUSY;
            cnt_d      = CNT_LOAD;
            acc_d      = {{XLEN{1'b0}}, a_mag};
            opb_d      = b_mag;
            is_div_d   = funct3[2];
            sel_hi_d   = funct3[2] ? funct3[1] : (funct3[1:0] != 2'd0);
            neg_d      = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
            lat_addr_d = rd_addr_i;
            lat_wen_d  = reg_wen_i & (rd_addr_i != 5'd0);
          end else begin
            rd_addr_d = rd_addr_i;
            rd_data_d = m_op ? special_res : alu_res;
            rd_wen_d  = (m_op | alu_ok) & reg_wen_i & (rd_addr_i != 5'd0);
          end
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          rd_addr_d = lat_addr_q;
          rd_data_d = fix_res;
          rd_wen_d  = lat_wen_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      sel_hi_q   <= 1'b0;
      neg_q      <= 1'b0;
      lat_addr_q <= 5'd0;
      lat_wen_q  <= 1'b0;
      rd_addr_q  <= 5'd0;
      rd_data_q  <= '0;
      rd_wen_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      sel_hi_q   <= sel_hi_d;
      neg_q      <= neg_d;
      lat_addr_q <= lat_addr_d;
      lat_wen_q  <= lat_wen_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_wen_q   <= rd_wen_d;
    end
  end

  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;
  assign rd_wen_o  = rd_wen_q;

endmodule
